replay_fifo: RTL

Parametrised FIFO with speculative read and replay. Written entries stay in storage after being read until the consumer commits them, and a replay rewinds the read pointer to the oldest uncommitted entry. It sits between the producer and the retransmitting consumer in the replay-buffer datapath. Compared with its predecessor it adds configurable width and depth, a correct full-depth count, concurrent read and write, and an overflow error flag.

---
 rtl/replay_fifo_pkg.sv | 14 +
 rtl/replay_fifo_mem.sv | 21 ++
 rtl/replay_fifo.sv | 76 +++++++
 3 files changed

// File: rtl/replay_fifo_pkg.sv
// replay_fifo_pkg: shared constants, status bundle and pointer arithmetic for replay_fifo.
package replay_fifo_pkg;
  localparam int DW_DEF = 16;
  localparam int DEPTH_DEF = 4096;
  typedef struct packed {
    logic empty;
    logic full;
    logic err;
  } status_t;
  // Pointers carry a wrap bit, so distances are taken modulo 2^(aw+1).
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b, input int aw);
    return (a - b) & ((32'd1 << (aw + 1)) - 32'd1);
  endfunction
endpackage

// File: rtl/replay_fifo_mem.sv
// replay_fifo_mem: simple dual-port RAM, synchronous write, registered read; the array itself is never reset.
module replay_fifo_mem #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/replay_fifo.sv
// replay_fifo: FIFO with speculative read, commit and replay of uncommitted entries.
// Optional REPLAY_FIFO_PROG_FLAGS_EN adds AF_THRESH/AE_THRESH and AFULL/AEMPTY outputs.
module replay_fifo import replay_fifo_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
`ifdef REPLAY_FIFO_PROG_FLAGS_EN
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
`endif
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          EN,
  input  logic          WR,
  input  logic [DW-1:0] dataIn,
  input  logic          RD,
  input  logic          COMMIT,
  input  logic          REPLAY,
  output logic [DW-1:0] dataOut,
  output logic          dataValid,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   Count,
`ifdef REPLAY_FIFO_PROG_FLAGS_EN
  output logic          AFULL,
  output logic          AEMPTY,
`endif
  output logic          ERR
);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr, ack_ptr;
  logic err_q, wr_ok, rd_ok, cm, rp;
  status_t st;
  always_comb begin
    Count = (AW+1)'(ptr_diff(32'(wr_ptr), 32'(ack_ptr), AW));
    st = '{empty: wr_ptr == rd_ptr, full: Count == FULL_CNT, err: err_q};
    wr_ok = EN & WR & !st.full;
    rd_ok = EN & RD & !st.empty & !REPLAY;
    cm = EN & COMMIT;
    rp = EN & REPLAY & !COMMIT;
  end
  assign EMPTY = st.empty;
  assign FULL = st.full;
  assign ERR = st.err;
`ifdef REPLAY_FIFO_PROG_FLAGS_EN
  assign AFULL = 32'(Count) >= 32'(AF_THRESH);
  assign AEMPTY = ptr_diff(32'(wr_ptr), 32'(rd_ptr), AW) <= 32'(AE_THRESH);
`endif
  // Commit captures the pre-edge read pointer, so a read in the same cycle stays uncommitted.
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ack_ptr <= '0;
      dataValid <= 1'b0;
      err_q <= 1'b0;
    end else begin
      dataValid <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rp ? ack_ptr : rd_ok ? rd_ptr + PTR_ONE : rd_ptr;
      if (cm) ack_ptr <= rd_ptr;
      if (EN & ((WR & st.full) | (RD & st.empty & !REPLAY))) err_q <= 1'b1;
    end
  replay_fifo_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk(Clk),
    .rst(Rst),
    .we(wr_ok),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(dataIn),
    .re(rd_ok),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(dataOut)
  );
endmodule
